// File: rtl/dbf_channel_gen.sv
// dbf_channel_gen: single-channel receive beamformer.
// Applies a dynamic-focus coarse delay from a circular sample buffer, a
// fractional fine delay by linear interpolation, apodization, then half-up
// rounding and saturation to the adder-tree width.
// Ports:
//   clk, rst_n      channel clock, synchronous active-low reset
//   start           level, high for one receive line
//   tx_en           transmit window, samples ignored while high
//   ch_in, apo_din  signed sample and its apodization weight
//   lut_addr/we/din focal LUT host write port, entry = {coarse, fraction}
//   dout/dout_valid beamformed sample and qualifier
//   cd_dout         debug: coarse-delayed sample x[k-c]
//   sat_flag        sticky saturation, cleared when start rises
module dbf_channel_gen #(
    parameter int unsigned INPUT_WD = 14,
    parameter int unsigned APO_WD   = 16,
    parameter int unsigned OUT_WD   = 16,
    parameter int unsigned BUF_AW   = 8,
    parameter int unsigned FRAC_WD  = 4,
    parameter int unsigned ADDR_WD  = 8,
    parameter int unsigned ZONE_LEN = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        tx_en,
    input  logic signed [INPUT_WD-1:0]  ch_in,
    input  logic signed [APO_WD-1:0]    apo_din,
    input  logic [ADDR_WD-1:0]          lut_addr,
    input  logic                        lut_we,
    input  logic [BUF_AW+FRAC_WD-1:0]   lut_din,
    output logic signed [OUT_WD-1:0]    dout,
    output logic                        dout_valid,
    output logic signed [INPUT_WD-1:0]  cd_dout,
    output logic                        sat_flag
);

    localparam int unsigned LW    = BUF_AW + FRAC_WD;
    localparam int unsigned KW    = BUF_AW + 1;
    localparam int unsigned IW    = INPUT_WD + FRAC_WD + 1;
    localparam int unsigned PW    = IW + APO_WD;
    localparam int unsigned SH    = FRAC_WD + APO_WD - 1;
    localparam int unsigned RW    = PW - SH;
    localparam int unsigned CW    = RW + OUT_WD;
    localparam int unsigned ZW    = (ZONE_LEN > 1) ? $clog2(ZONE_LEN) : 1;
    localparam int unsigned DEPTH = 1 << BUF_AW;
    localparam int unsigned NZ    = 1 << ADDR_WD;

    localparam logic signed [PW-1:0] HALF = PW'(1) << (SH - 1);
    localparam logic signed [CW-1:0] OMAX = (CW'(1) << (OUT_WD - 1)) - CW'(1);
    localparam logic signed [CW-1:0] OMIN = ~OMAX;

    typedef enum logic {IDLE, RUN} state_e;

    state_e                      state_q;
    logic [BUF_AW-1:0]           wr_ptr_q;
    logic [KW-1:0]               fill_q;      // samples this line, saturating at DEPTH
    logic [ZW-1:0]               zcnt_q;
    logic [ADDR_WD-1:0]          zone_q;

    logic [LW-1:0]               lut_mem [NZ];
    logic [LW-1:0]               lut_rd_q;
    logic signed [INPUT_WD-1:0]  buf_mem [DEPTH];
    logic signed [INPUT_WD-1:0]  buf0_q, buf1_q;

    // Pipeline registers, numbered by the edge after acceptance that loads them
    logic                        v1_q, v2_q, v3_q, v4_q, v5_q;
    logic [KW-1:0]               k1_q;
    logic [BUF_AW-1:0]           wp1_q;
    logic signed [APO_WD-1:0]    apo1_q, apo2_q, apo3_q;
    logic                        neg0_q, neg1_q;
    logic [FRAC_WD-1:0]          f2_q;
    logic signed [IW-1:0]        i3_q;
    logic signed [PW-1:0]        p4_q;
    logic signed [RW-1:0]        r5_q;
    logic                        sat_q;

    logic                        accept_c, abort_c;
    logic [BUF_AW-1:0]           c1_c, rd0_c, rd1_c;
    logic [FRAC_WD-1:0]          f1_c;
    logic signed [INPUT_WD-1:0]  x0_d, x1_d;
    logic signed [IW-1:0]        x0e_d, x1e_d, fe_d, i_d;
    logic signed [PW-1:0]        p_d, rsum_d;
    logic signed [RW-1:0]        r_d;
    logic signed [CW-1:0]        ext_d;
    logic                        pos_sat_d, neg_sat_d;

    // start high covers both RUN and the IDLE->RUN cycle
    assign accept_c = start & ~tx_en;
    assign abort_c  = (state_q == RUN) & ~start;

    assign c1_c  = lut_rd_q[LW-1:FRAC_WD];
    assign f1_c  = lut_rd_q[FRAC_WD-1:0];
    assign rd0_c = wp1_q - c1_c;
    assign rd1_c = rd0_c - BUF_AW'(1);

    // Host LUT write; registered read returns old data on same-address collision
    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut_mem[lut_addr] <= lut_din;
        end
        lut_rd_q <= lut_mem[zone_q];
    end

    // Sample buffer: write at S0, read both taps at S1 (old data if slot is being rewritten)
    always_ff @(posedge clk) begin
        if (accept_c) begin
            buf_mem[wr_ptr_q] <= ch_in;
        end
        buf0_q <= buf_mem[rd0_c];
        buf1_q <= buf_mem[rd1_c];
    end

    // Interpolate, apodize, round
    always_comb begin
        x0_d   = neg0_q ? '0 : buf0_q;
        x1_d   = neg1_q ? '0 : buf1_q;
        x0e_d  = IW'(x0_d);
        x1e_d  = IW'(x1_d);
        fe_d   = IW'(f2_q);
        i_d    = (x0e_d <<< FRAC_WD) + fe_d * (x1e_d - x0e_d);
        p_d    = PW'(i3_q) * PW'(apo3_q);
        rsum_d = p4_q + HALF;
        r_d    = RW'(rsum_d >>> SH);
        ext_d  = CW'(r5_q);
        pos_sat_d = (ext_d > OMAX);
        neg_sat_d = (ext_d < OMIN);
    end

    // State, counters, pipeline and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            zcnt_q     <= '0;
            zone_q     <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            v4_q       <= 1'b0;
            v5_q       <= 1'b0;
            k1_q       <= '0;
            wp1_q      <= '0;
            apo1_q     <= '0;
            apo2_q     <= '0;
            apo3_q     <= '0;
            neg0_q     <= 1'b1;
            neg1_q     <= 1'b1;
            f2_q       <= '0;
            i3_q       <= '0;
            p4_q       <= '0;
            r5_q       <= '0;
            sat_q      <= 1'b0;
            cd_dout    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (abort_c) begin
                // Line ended: drop in-flight samples and restart indexing
                wr_ptr_q   <= '0;
                fill_q     <= '0;
                zcnt_q     <= '0;
                zone_q     <= '0;
                v1_q       <= 1'b0;
                v2_q       <= 1'b0;
                v3_q       <= 1'b0;
                v4_q       <= 1'b0;
                v5_q       <= 1'b0;
                dout       <= '0;
                dout_valid <= 1'b0;
            end else begin
                if (accept_c) begin
                    wr_ptr_q <= wr_ptr_q + BUF_AW'(1);
                    if (fill_q != KW'(DEPTH)) begin
                        fill_q <= fill_q + KW'(1);
                    end
                    if (zcnt_q == ZW'(ZONE_LEN - 1)) begin
                        zcnt_q <= '0;
                        if (zone_q != ADDR_WD'(NZ - 1)) begin
                            zone_q <= zone_q + ADDR_WD'(1);
                        end
                    end else begin
                        zcnt_q <= zcnt_q + ZW'(1);
                    end
                end
                // S0
                v1_q   <= accept_c;
                k1_q   <= fill_q;
                wp1_q  <= wr_ptr_q;
                apo1_q <= apo_din;
                // S1: taps before line start read as zero
                v2_q   <= v1_q;
                neg0_q <= (k1_q <  {1'b0, c1_c});
                neg1_q <= (k1_q <= {1'b0, c1_c});
                f2_q   <= f1_c;
                apo2_q <= apo1_q;
                // S2
                v3_q   <= v2_q;
                i3_q   <= i_d;
                apo3_q <= apo2_q;
                if (v2_q) begin
                    cd_dout <= x0_d;
                end
                // S3
                v4_q <= v3_q;
                p4_q <= p_d;
                // S4
                v5_q <= v4_q;
                r5_q <= r_d;
                // Output: dout holds across bubbles
                dout_valid <= v5_q;
                if (v5_q) begin
                    if (pos_sat_d) begin
                        dout <= OUT_WD'(OMAX);
                    end else if (neg_sat_d) begin
                        dout <= OUT_WD'(OMIN);
                    end else begin
                        dout <= OUT_WD'(ext_d);
                    end
                    if (pos_sat_d || neg_sat_d) begin
                        sat_q <= 1'b1;
                    end
                end
            end

            unique case (state_q)
                IDLE: if (start) begin
                    state_q <= RUN;
                    sat_q   <= 1'b0;
                end
                RUN: if (!start) begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sat_flag = sat_q;

endmodule

// File: tb/tb_dbf_channel_gen.sv
// Scoreboard bench for dbf_channel_gen (OUT_WD=12, ZONE_LEN=4).
module tb_dbf_channel_gen;

    localparam int unsigned IW_P = 14;
    localparam int unsigned AW_P = 16;
    localparam int unsigned OW_P = 12;
    localparam int unsigned BA_P = 8;
    localparam int unsigned FW_P = 4;
    localparam int unsigned AD_P = 8;

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic                    tx_en;
    logic signed [IW_P-1:0]  ch_in;
    logic signed [AW_P-1:0]  apo_din;
    logic [AD_P-1:0]         lut_addr;
    logic                    lut_we;
    logic [BA_P+FW_P-1:0]    lut_din;
    logic signed [OW_P-1:0]  dout;
    logic                    dout_valid;
    logic signed [IW_P-1:0]  cd_dout;
    logic                    sat_flag;

    dbf_channel_gen #(
        .INPUT_WD(IW_P), .APO_WD(AW_P), .OUT_WD(OW_P), .BUF_AW(BA_P),
        .FRAC_WD(FW_P), .ADDR_WD(AD_P), .ZONE_LEN(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_en(tx_en),
        .ch_in(ch_in), .apo_din(apo_din), .lut_addr(lut_addr),
        .lut_we(lut_we), .lut_din(lut_din), .dout(dout),
        .dout_valid(dout_valid), .cd_dout(cd_dout), .sat_flag(sat_flag)
    );

    typedef struct {
        int due;
        int t;
        int val;
        int k;
    } exp_t;

    exp_t  dq[$];
    exp_t  cq[$];
    exp_t  me;
    int    cyc = 0;
    int    kk = 0;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 0;
    string tname = "reset";

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expected output when dout_valid or its due cycle arrives
    always @(negedge clk) begin
        if (mon_en) begin
            if (dout_valid) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected_valid: dout=%0d at cycle %0d, required no valid", tname, dout, cyc);
                end else begin
                    me = dq.pop_front();
                    if (me.due != cyc || int'(dout) != me.val) begin
                        errors++;
                        $display("FAIL %s dout k=%0d: got %0d at cycle %0d, required %0d at cycle %0d",
                                 tname, me.k, dout, cyc, me.val, me.due);
                    end
                end
            end else if (dq.size() != 0 && dq[0].due <= cyc) begin
                me = dq.pop_front();
                checks++;
                errors++;
                $display("FAIL %s missing_valid k=%0d: got dout_valid=0 at cycle %0d, required %0d", tname, me.k, cyc, me.val);
            end
            if (cq.size() != 0 && cq[0].due <= cyc) begin
                me = cq.pop_front();
                checks++;
                if (me.due != cyc || int'(cd_dout) != me.val) begin
                    errors++;
                    $display("FAIL %s cd_dout k=%0d: got %0d at cycle %0d, required %0d", tname, me.k, cd_dout, cyc, me.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s %s: got %0d required %0d", tname, nm, got, req);
        end
    endtask

    task automatic lut_set(input int a, input int c, input int f);
        lut_addr = AD_P'(a);
        lut_din  = 12'((c << FW_P) | f);
        lut_we   = 1'b1;
        tick();
        lut_we   = 1'b0;
    endtask

    task automatic lut_fill(input int c, input int f);
        for (int a = 0; a < 256; a++) lut_set(a, c, f);
    endtask

    // One accepted sample with hand-computed dout and cd_dout
    task automatic acc(input int x, input int a, input int ed, input int ec);
        start   = 1'b1;
        tx_en   = 1'b0;
        ch_in   = IW_P'(x);
        apo_din = AW_P'(a);
        dq.push_back('{cyc + 6, cyc + 1, ed, kk});
        cq.push_back('{cyc + 3, cyc + 1, ec, kk});
        kk++;
        tick();
    endtask

    task automatic gap();
        start   = 1'b1;
        tx_en   = 1'b1;
        ch_in   = IW_P'($urandom);
        apo_din = AW_P'($urandom);
        tick();
    endtask

    // Drop start; anything still in flight at that edge is discarded
    task automatic abort_line();
        int   a;
        exp_t keep[$];
        a = cyc + 1;
        start = 1'b0;
        tx_en = 1'b0;
        keep.delete();
        foreach (dq[i]) if (dq[i].t + 5 < a) keep.push_back(dq[i]);
        dq = keep;
        keep.delete();
        foreach (cq[i]) if (cq[i].t + 2 < a) keep.push_back(cq[i]);
        cq = keep;
        tick();
        chk("abort_dout_valid", int'(dout_valid), 0);
        chk("abort_dout", int'(dout), 0);
        kk = 0;
    endtask

    task automatic drain();
        for (int n = 0; n < 20; n++) begin
            if (dq.size() == 0 && cq.size() == 0) break;
            gap();
        end
        if (dq.size() != 0 || cq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s drain_timeout: got %0d pending, required 0", tname, dq.size() + cq.size());
            dq.delete();
            cq.delete();
        end
    endtask

    int ez[9] = '{50, 100, 150, 200, 150, 200, 250, 300, 350};

    initial begin
        rst_n = 1'b0; start = 1'b0; tx_en = 1'b0; ch_in = '0; apo_din = '0;
        lut_addr = '0; lut_we = 1'b0; lut_din = '0;
        tick();
        lut_fill(0, 0);

        // Reset held with start high and input toggling
        for (int n = 0; n < 3; n++) begin
            start = 1'b1;
            ch_in = (n % 2 == 0) ? IW_P'(1234) : IW_P'(-777);
            apo_din = AW_P'(16384);
            tick();
            chk("rst_dout", int'(dout), 0);
            chk("rst_dout_valid", int'(dout_valid), 0);
            chk("rst_sat_flag", int'(sat_flag), 0);
            mon_en = 1'b1;
        end
        rst_n = 1'b1;

        tname = "passthrough";
        for (int n = 0; n < 12; n++) acc(4 * n, 16384, 2 * n, 4 * n);
        // Rounding (half-up) and weight variations
        acc(1, 16384, 1, 1);
        acc(-1, 16384, 0, -1);
        acc(3, 16384, 2, 3);
        acc(-3, 16384, -1, -3);
        acc(100, -16384, -50, 100);
        acc(1000, 8192, 250, 1000);
        drain();
        chk("sat_flag_clear", int'(sat_flag), 0);
        abort_line();
        tick();

        tname = "coarse";
        lut_fill(3, 0);
        acc(1000, 16384, 0, 0);
        acc(0, 16384, 0, 0);
        acc(0, 16384, 0, 0);
        acc(0, 16384, 500, 1000);
        for (int n = 0; n < 4; n++) acc(0, 16384, 0, 0);
        drain();
        abort_line();
        tick();

        tname = "fine";
        lut_fill(0, 8);
        acc(1000, 16384, 250, 1000);
        acc(0, 16384, 250, 0);
        for (int n = 0; n < 4; n++) acc(0, 16384, 0, 0);
        drain();
        abort_line();
        tick();

        tname = "saturate";
        lut_fill(0, 0);
        acc(-8192, -32768, 2047, -8192);
        acc(-8192, 32767, -2048, -8192);
        acc(5, 16384, 3, 5);
        drain();
        chk("sat_flag_set", int'(sat_flag), 1);
        abort_line();
        chk("sat_flag_sticky", int'(sat_flag), 1);
        start = 1'b1;
        tx_en = 1'b1;
        tick();
        chk("sat_flag_restart", int'(sat_flag), 0);
        abort_line();
        tick();

        tname = "zones";
        lut_fill(2, 0);
        lut_set(0, 0, 0);
        tick();
        for (int k = 0; k < 9; k++) begin
            acc(100 * (k + 1), 16384, ez[k], 2 * ez[k]);
            if (k % 2 == 1) gap();
        end
        abort_line();
        for (int n = 0; n < 8; n++) tick();
        chk("zones_idle_valid", int'(dout_valid), 0);
        chk("zones_pending", dq.size() + cq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
